// File: rtl/proc_cmd_receiver_if.sv
// Issuer-to-processor command handshake bundle.
// master = issuer side, slave = per-processor receiver.
interface proc_cmd_receiver_if #(
  parameter int INSTR_W = 30
) ();
  logic               i_en;
  logic               i_valid;
  logic [INSTR_W-1:0] i_instr;
  logic               o_ack;
  logic               o_busy;
  logic               o_finish;
  logic               i_finish_ack;
  logic               o_err;

  modport master (
    output i_en,
    output i_valid,
    output i_instr,
    output i_finish_ack,
    input  o_ack,
    input  o_busy,
    input  o_finish,
    input  o_err
  );

  modport slave (
    input  i_en,
    input  i_valid,
    input  i_instr,
    input  i_finish_ack,
    output o_ack,
    output o_busy,
    output o_finish,
    output o_err
  );
endinterface

// File: rtl/proc_cmd_receiver.sv
// Per-processor command receiver: collects LD, LD, INFO,
// launches the datapath and holds finish until acknowledged.
module proc_cmd_receiver #(
  parameter int ADDR_W  = 16,
  parameter int COUNT_W = 8,
  parameter int FN_W    = 4,
  parameter int OPC_W   = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  proc_cmd_receiver_if.slave iss,
  output logic               o_start,
  output logic [ADDR_W-1:0]  o_addr0,
  output logic [ADDR_W-1:0]  o_addr1,
  output logic [COUNT_W-1:0] o_count,
  output logic [FN_W-1:0]    o_fn,
  output logic [ADDR_W-1:0]  o_wr_addr,
  input  logic               i_done
);

  localparam int PAYLOAD_W = COUNT_W + FN_W + ADDR_W;
  localparam int INSTR_W   = OPC_W + PAYLOAD_W;

  localparam logic [OPC_W-1:0] INSTR_LD   = OPC_W'(1);
  localparam logic [OPC_W-1:0] INSTR_INFO = OPC_W'(2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_LD0,
    S_RX_LD1,
    S_RX_INFO,
    S_EXEC,
    S_FINISH
  } state_e;

  state_e state_q, state_d;

  logic ack_q, ack_d;
  logic err_q, err_d;
  logic start_q, start_d;
  logic busy_q, busy_d;
  logic finish_q, finish_d;

  logic [ADDR_W-1:0]  addr0_q, addr0_d;
  logic [ADDR_W-1:0]  addr1_q, addr1_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [FN_W-1:0]    fn_q, fn_d;
  logic [ADDR_W-1:0]  wr_q, wr_d;

  logic [OPC_W-1:0]   opc;
  logic [ADDR_W-1:0]  f_addr;
  logic [COUNT_W-1:0] f_count;
  logic [FN_W-1:0]    f_fn;
  logic               is_ld;
  logic               is_info;

  // Field slices of the incoming instruction word.
  assign opc     = iss.i_instr[INSTR_W-1 -: OPC_W];
  assign f_addr  = iss.i_instr[ADDR_W-1:0];
  assign f_fn    = iss.i_instr[ADDR_W+FN_W-1 -: FN_W];
  assign f_count = iss.i_instr[PAYLOAD_W-1 -: COUNT_W];
  assign is_ld   = iss.i_valid && (opc == INSTR_LD);
  assign is_info = iss.i_valid && (opc == INSTR_INFO);

  // Next-state and next-output decode for the command FSM.
  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    start_d = 1'b0;
    addr0_d = addr0_q;
    addr1_d = addr1_q;
    count_d = count_q;
    fn_d    = fn_q;
    wr_d    = wr_q;
    unique case (state_q)
      S_IDLE: begin
        err_d = iss.i_valid;
        if (iss.i_en) state_d = S_RX_LD0;
      end
      S_RX_LD0: begin
        if (is_ld) begin
          addr0_d = f_addr;
          ack_d   = 1'b1;
          state_d = S_RX_LD1;
        end else begin
          err_d = iss.i_valid;
        end
      end
      S_RX_LD1: begin
        if (is_ld) begin
          addr1_d = f_addr;
          ack_d   = 1'b1;
          state_d = S_RX_INFO;
        end else begin
          err_d = iss.i_valid;
        end
      end
      S_RX_INFO: begin
        if (is_info) begin
          count_d = f_count;
          fn_d    = f_fn;
          wr_d    = f_addr;
          ack_d   = 1'b1;
          if (f_count != '0) begin
            start_d = 1'b1;
            state_d = S_EXEC;
          end else begin
            state_d = S_FINISH;
          end
        end else begin
          err_d = iss.i_valid;
        end
      end
      S_EXEC: begin
        err_d = iss.i_valid;
        if (i_done) state_d = S_FINISH;
      end
      S_FINISH: begin
        err_d = iss.i_valid;
        if (iss.i_finish_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d   = (state_d != S_IDLE);
    finish_d = (state_d == S_FINISH);
  end

  // State, handshake outputs and descriptor registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      finish_q <= 1'b0;
      addr0_q  <= '0;
      addr1_q  <= '0;
      count_q  <= '0;
      fn_q     <= '0;
      wr_q     <= '0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      finish_q <= finish_d;
      addr0_q  <= addr0_d;
      addr1_q  <= addr1_d;
      count_q  <= count_d;
      fn_q     <= fn_d;
      wr_q     <= wr_d;
    end
  end

  assign iss.o_ack    = ack_q;
  assign iss.o_err    = err_q;
  assign iss.o_busy   = busy_q;
  assign iss.o_finish = finish_q;
  assign o_start      = start_q;
  assign o_addr0      = addr0_q;
  assign o_addr1      = addr1_q;
  assign o_count      = count_q;
  assign o_fn         = fn_q;
  assign o_wr_addr    = wr_q;

endmodule

// File: tb/tb_proc_cmd_receiver.sv
// Scoreboard bench for proc_cmd_receiver: stimulus queues
// expected output events, a negedge monitor pops and compares.
module tb_proc_cmd_receiver;

  localparam int INSTR_W = 30;

  typedef enum int {
    EV_BUSY, EV_ACK, EV_START, EV_ERR, EV_FIN, EV_FREE
  } ev_e;

  typedef struct {
    ev_e         kind;
    int          cyc;
    logic [15:0] a0;
    logic [15:0] a1;
    logic [7:0]  cnt;
    logic [3:0]  fn;
    logic [15:0] wr;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [15:0] addr0, addr1, wr_addr;
  logic [7:0] count;
  logic [3:0] fn;
  logic done;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  ev_t sbq[$];
  logic prev_busy = 1'b0;
  logic prev_fin = 1'b0;

  proc_cmd_receiver_if #(.INSTR_W(INSTR_W)) bus ();

  proc_cmd_receiver dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .iss       (bus),
    .o_start   (start),
    .o_addr0   (addr0),
    .o_addr1   (addr1),
    .o_count   (count),
    .o_fn      (fn),
    .o_wr_addr (wr_addr),
    .i_done    (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cyc %0d: got %0h want %0h",
               nm, cyc, act, exp);
    end
  endtask

  task automatic push(input ev_e k, input int c);
    ev_t e;
    e.kind = k; e.cyc = c;
    e.a0 = '0; e.a1 = '0; e.cnt = '0; e.fn = '0; e.wr = '0;
    sbq.push_back(e);
  endtask

  task automatic push_start(input int c,
                            input logic [15:0] a0,
                            input logic [15:0] a1,
                            input logic [7:0] cnt,
                            input logic [3:0] f,
                            input logic [15:0] wr);
    ev_t e;
    e.kind = EV_START; e.cyc = c;
    e.a0 = a0; e.a1 = a1; e.cnt = cnt; e.fn = f; e.wr = wr;
    sbq.push_back(e);
  endtask

  task automatic got(input ev_e k);
    ev_t e;
    if (sbq.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_event at cyc %0d: got %s want none",
               cyc, k.name());
    end else begin
      e = sbq.pop_front();
      check("ev_kind", 32'(k), 32'(e.kind));
      check("ev_cyc", 32'(cyc), 32'(e.cyc));
      if (k == EV_START) begin
        check("start_addr0", 32'(addr0), 32'(e.a0));
        check("start_addr1", 32'(addr1), 32'(e.a1));
        check("start_count", 32'(count), 32'(e.cnt));
        check("start_fn", 32'(fn), 32'(e.fn));
        check("start_wr", 32'(wr_addr), 32'(e.wr));
      end
      if (k == EV_FREE) check("free_finish", 32'(bus.o_finish), 32'd0);
    end
  endtask

  // Output monitor: each pulse or level edge consumes one event.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_busy && !prev_busy) got(EV_BUSY);
      if (bus.o_ack) got(EV_ACK);
      if (start) got(EV_START);
      if (bus.o_err) got(EV_ERR);
      if (bus.o_finish && !prev_fin) got(EV_FIN);
      if (!bus.o_busy && prev_busy) got(EV_FREE);
      prev_busy = bus.o_busy;
      prev_fin = bus.o_finish;
    end
  end

  function automatic logic [29:0] ld(input logic [15:0] a);
    return {2'd1, 12'h000, a};
  endfunction

  function automatic logic [29:0] info(input logic [7:0] c,
                                       input logic [3:0] f,
                                       input logic [15:0] w);
    return {2'd2, c, f, w};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [29:0] w);
    bus.i_valid = 1'b1;
    bus.i_instr = w;
    tick();
    bus.i_valid = 1'b0;
    bus.i_instr = ~w;
  endtask

  task automatic do_en();
    bus.i_en = 1'b1;
    push(EV_BUSY, cyc + 1);
    tick();
    bus.i_en = 1'b0;
  endtask

  task automatic b2b(input logic [15:0] a0,
                     input logic [15:0] a1,
                     input logic [7:0] c,
                     input logic [3:0] f,
                     input logic [15:0] w);
    do_en();
    push(EV_ACK, cyc + 1);
    send(ld(a0));
    push(EV_ACK, cyc + 1);
    send(ld(a1));
    push(EV_ACK, cyc + 1);
    push_start(cyc + 1, a0, a1, c, f, w);
    send(info(c, f, w));
    done = 1'b1;
    push(EV_FIN, cyc + 1);
    tick();
    done = 1'b0;
    bus.i_finish_ack = 1'b1;
    push(EV_FREE, cyc + 1);
    tick();
    bus.i_finish_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    done = 1'b0;
    bus.i_en = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_instr = '0;
    bus.i_finish_ack = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    check("rst_finish", 32'(bus.o_finish), 32'd0);
    check("rst_ack", 32'(bus.o_ack), 32'd0);
    check("rst_start", 32'(start), 32'd0);
    check("rst_addr0", 32'(addr0), 32'd0);
    check("rst_count", 32'(count), 32'd0);

    // nominal command with gaps
    do_en();
    push(EV_ACK, cyc + 1);
    send(ld(16'h0100));
    tick();
    push(EV_ACK, cyc + 1);
    send(ld(16'h0200));
    tick();
    push(EV_ACK, cyc + 1);
    push_start(cyc + 1, 16'h0100, 16'h0200, 8'd4, 4'd3, 16'h0300);
    send(info(8'd4, 4'd3, 16'h0300));
    repeat (3) tick();
    done = 1'b1;
    push(EV_FIN, cyc + 1);
    tick();
    done = 1'b0;
    tick();
    check("nom_finish_held", 32'(bus.o_finish), 32'd1);
    check("nom_busy_held", 32'(bus.o_busy), 32'd1);
    tick();
    bus.i_finish_ack = 1'b1;
    push(EV_FREE, cyc + 1);
    tick();
    bus.i_finish_ack = 1'b0;
    check("nom_busy_clr", 32'(bus.o_busy), 32'd0);

    // stray done and valid in IDLE
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    check("idle_done_fin", 32'(bus.o_finish), 32'd0);
    check("idle_done_busy", 32'(bus.o_busy), 32'd0);
    push(EV_ERR, cyc + 1);
    send(ld(16'h1234));
    check("idle_err_busy", 32'(bus.o_busy), 32'd0);

    // back-to-back with single-cycle op
    b2b(16'hA001, 16'hA002, 8'd16, 4'd7, 16'hA003);

    // count == 0 goes straight to FINISH
    do_en();
    push(EV_ACK, cyc + 1);
    send(ld(16'h0011));
    push(EV_ACK, cyc + 1);
    send(ld(16'h0022));
    push(EV_ACK, cyc + 1);
    push(EV_FIN, cyc + 1);
    send(info(8'd0, 4'd5, 16'h0ABC));
    check("c0_count", 32'(count), 32'd0);
    check("c0_fn", 32'(fn), 32'd5);
    check("c0_wr", 32'(wr_addr), 32'h0ABC);
    tick();
    bus.i_finish_ack = 1'b1;
    push(EV_FREE, cyc + 1);
    tick();
    bus.i_finish_ack = 1'b0;

    // protocol errors
    do_en();
    push(EV_ERR, cyc + 1);
    send(info(8'd7, 4'd9, 16'h7777));
    check("err_info_count", 32'(count), 32'd0);
    check("err_info_fn", 32'(fn), 32'd5);
    push(EV_ERR, cyc + 1);
    send({2'd3, 12'hFFF, 16'h5555});
    check("err_op3_addr0", 32'(addr0), 32'h0011);
    push(EV_ERR, cyc + 1);
    send({2'd0, 12'h000, 16'h6666});
    push(EV_ACK, cyc + 1);
    send(ld(16'h0A00));
    push(EV_ACK, cyc + 1);
    send(ld(16'h0B00));
    push(EV_ACK, cyc + 1);
    push_start(cyc + 1, 16'h0A00, 16'h0B00, 8'd2, 4'd6, 16'h0C00);
    send(info(8'd2, 4'd6, 16'h0C00));
    bus.i_finish_ack = 1'b1;
    tick();
    bus.i_finish_ack = 1'b0;
    push(EV_ERR, cyc + 1);
    send(ld(16'hDEAD));
    check("exec_err_addr0", 32'(addr0), 32'h0A00);
    check("exec_err_busy", 32'(bus.o_busy), 32'd1);
    check("exec_stray_fin", 32'(bus.o_finish), 32'd0);
    done = 1'b1;
    push(EV_FIN, cyc + 1);
    tick();
    done = 1'b0;
    push(EV_ERR, cyc + 1);
    send(ld(16'hBEEF));
    check("fin_err_finish", 32'(bus.o_finish), 32'd1);
    check("fin_err_addr0", 32'(addr0), 32'h0A00);
    bus.i_finish_ack = 1'b1;
    push(EV_FREE, cyc + 1);
    tick();
    bus.i_finish_ack = 1'b0;

    // reset while executing
    do_en();
    push(EV_ACK, cyc + 1);
    send(ld(16'h1111));
    push(EV_ACK, cyc + 1);
    send(ld(16'h2222));
    push(EV_ACK, cyc + 1);
    push_start(cyc + 1, 16'h1111, 16'h2222, 8'd9, 4'd1, 16'h3333);
    send(info(8'd9, 4'd1, 16'h3333));
    tick();
    rst = 1'b1;
    push(EV_FREE, cyc + 1);
    tick();
    rst = 1'b0;
    check("mid_rst_busy", 32'(bus.o_busy), 32'd0);
    check("mid_rst_finish", 32'(bus.o_finish), 32'd0);
    check("mid_rst_addr0", 32'(addr0), 32'd0);
    check("mid_rst_addr1", 32'(addr1), 32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_fn", 32'(fn), 32'd0);
    check("mid_rst_wr", 32'(wr_addr), 32'd0);
    b2b(16'h4444, 16'h5555, 8'd1, 4'd2, 16'h6666);

    repeat (4) tick();
    check("sb_empty", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/proc_cmd_receiver.md
# proc_cmd_receiver

Per-processor command receiver that terminates the issuer-to-SIMD-processor instruction protocol. It:
- accepts the three-instruction command sequence (LD operand 0, LD operand 1, INFO);
- acknowledges each instruction;
- presents the assembled descriptor to the processor datapath and raises busy/finish toward the issuer;
- drops finish on the issuer's finish acknowledge.

One instance sits in front of each SIMD processor, indexed by the issuer's per-processor en/ack/busy/finish bits.

## Interface
Parameters:
- ADDR_W, 16, operand/write address width.
- COUNT_W, 8, element count width.
- FN_W, 4, datapath operation code width.
- OPC_W, 2, instruction opcode width; INSTR_LD = 1, INSTR_INFO = 2, all others illegal.
- Derived: PAYLOAD_W = COUNT_W+FN_W+ADDR_W; INSTR_W = OPC_W+PAYLOAD_W.
  - The instruction word is {opcode, payload}.
  - LD carries its address in payload[ADDR_W-1:0].
  - INFO payload is {count, fn, wr_addr}, MSB to LSB.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - i_clk  in  1  clock.
  - i_rst  in  1  reset.
- Issuer side:
  - i_en  in  1  issuer selects this processor.
  - i_valid  in  1  i_instr valid this cycle.
  - i_instr  in  INSTR_W  instruction word.
  - o_ack  out  1  one-cycle instruction acknowledge.
  - o_busy  out  1  processor owned by a command.
  - o_finish  out  1  command complete, awaiting ack.
  - i_finish_ack  in  1  issuer acknowledges finish.
  - o_err  out  1  one-cycle protocol-violation pulse.
- Datapath side:
  - o_start  out  1  one-cycle execute pulse.
  - o_addr0  out  ADDR_W  descriptor operand 0 address.
  - o_addr1  out  ADDR_W  descriptor operand 1 address.
  - o_count  out  COUNT_W  descriptor element count.
  - o_fn  out  FN_W  descriptor operation code.
  - o_wr_addr  out  ADDR_W  descriptor write address.
  - i_done  in  1  datapath finished.

## Operation
- States: IDLE, RX_LD0, RX_LD1, RX_INFO, EXEC, FINISH.
- IDLE:
  - i_en=1 -> RX_LD0; o_busy rises next cycle.
  - i_valid in IDLE -> o_err pulse, no ack.
- RX_LD0:
  - i_valid with opcode LD -> capture addr0, o_ack pulse, go to RX_LD1.
- RX_LD1:
  - i_valid with opcode LD -> capture addr1, o_ack pulse, go to RX_INFO.
- RX_INFO:
  - i_valid with opcode INFO -> capture count/fn/wr_addr, o_ack pulse.
  - count != 0 -> EXEC, with o_start pulsed in the same cycle the state becomes EXEC.
  - count == 0 -> FINISH directly; no o_start.
- Wrong opcode in any RX_* state -> o_err pulse, no o_ack, state and captured fields unchanged.
- EXEC:
  - i_done=1 -> FINISH.
  - i_valid -> o_err, ignored.
- FINISH:
  - o_finish=1, held.
  - i_finish_ack=1 -> IDLE; o_finish and o_busy clear next cycle.
  - i_valid -> o_err, ignored.
- Ignored inputs:
  - i_done outside EXEC.
  - i_finish_ack outside FINISH.
  - i_en outside IDLE.
- o_busy=1 in every state except IDLE.
- Descriptor outputs are registers:
  - written only on an accepted instruction;
  - stable from capture until the next accepted instruction of the same kind;
  - never combinationally driven from i_instr.

## Timing
- All outputs are registered. Reset values: o_ack, o_busy, o_finish, o_err, o_start = 0; all descriptor outputs = 0; state = IDLE.
- i_rst has priority over every other input in the same cycle. Asserting it mid-command, in any state, returns the block to IDLE with reset values the following cycle. No o_ack or o_finish is emitted for the aborted command.
- i_en sampled at cycle t in IDLE -> o_busy=1 at t+1. The first LD may arrive at t+1.
- Instruction acceptance:
  - i_valid sampled at t -> o_ack=1 at t+1 for exactly one cycle.
  - The captured field is visible at t+1.
  - i_instr only needs to be valid in cycle t; the issuer drops it during its ack wait.
- Back-to-back i_valid in consecutive cycles is legal. Each accepted instruction gets its own o_ack, one cycle later.
- INFO accepted at t -> o_start=1 at t+1, with the full descriptor valid at t+1.
- i_done at d in EXEC -> o_finish=1 at d+1. i_done in the same cycle as the o_start pulse is legal (single-cycle op).
- i_finish_ack at f in FINISH:
  - o_finish=0 and o_busy=0 at f+1;
  - i_en accepted from f+1.
- o_err is asserted at t+1 for an offending i_valid at t, for exactly one cycle.

## Test plan
- Nominal command:
  - Stimulus: en at t0; LD 0x0100 at t0+1; LD 0x0200 at t0+3; INFO {count=4, fn=3, wr=0x0300} at t0+5.
  - Required: o_ack at t0+2, t0+4 and t0+6; o_start at t0+6 with addr0=0x0100, addr1=0x0200, count=4, fn=3, wr_addr=0x0300.
  - Then: i_done at t0+9 -> o_finish at t0+10; i_finish_ack at t0+12 -> o_busy=0 at t0+13.
- Back-to-back: LD, LD, INFO on three consecutive cycles -> three consecutive o_ack pulses and o_start coincident with the third o_ack.
- count=0:
  - INFO with count 0 -> no o_start, o_finish the next cycle.
  - Then: i_finish_ack returns the block to IDLE.
- Protocol errors:
  - INFO while in RX_LD0 -> o_err pulse, no o_ack, state stays RX_LD0.
  - Opcode 3 -> same behaviour.
  - i_valid in EXEC -> o_err, descriptor unchanged.
- Reset mid-command: i_rst while in EXEC with o_busy=1 -> all outputs 0 and IDLE the next cycle. A subsequent full command completes normally.
- Stray handshakes: i_done in IDLE and i_finish_ack in EXEC -> no state change, no o_finish.
